// File: rtl/perfil_pkg.sv
// perfil_pkg: profile code constants, session FSM states and the profile-to-flags decode.
package perfil_pkg;
  localparam logic [1:0] PERFIL_ADM    = 2'b11;
  localparam logic [1:0] PERFIL_TESTER = 2'b10;
  localparam logic [1:0] PERFIL_USER   = 2'b01;
  localparam logic [1:0] PERFIL_GUEST  = 2'b00;
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE, EXPIRED} estado_t;
  function automatic logic [2:0] decode_perfil(input logic [1:0] code);
    logic [2:0] abc;
    case (code)
      PERFIL_ADM:    abc = 3'b101;
      PERFIL_TESTER: abc = 3'b001;
      PERFIL_USER:   abc = 3'b011;
      PERFIL_GUEST:  abc = 3'b000;
    endcase
    return abc;
  endfunction
endpackage

// File: rtl/temporizador_sessao.sv
// temporizador_sessao: inactivity counter, flags expiry on its last count.
module temporizador_sessao #(
  parameter int TIMEOUT_CYCLES = 8,
  parameter int CNT_W = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expira
);
  logic [CNT_W-1:0] count;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= count + CNT_W'(1);
  assign expira = count == CNT_W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/decodificador_perfil_binario.sv
// decodificador_perfil_binario: expands a 2-bit profile code into session-held A/B/C flags
// with logout and inactivity expiry.
module decodificador_perfil_binario
  import perfil_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] perfil_in,
  input  logic       perfil_valid,
  output logic       perfil_ready,
  input  logic       logout,
  input  logic       activity,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic [1:0] perfil_atual,
  output logic       sessao_ativa,
  output logic       timeout_pulse
);
  estado_t state;
  logic [1:0] codigo;
  logic expira;
  assign perfil_ready = (state == IDLE) & ~reset;
  // The counter only runs in ACTIVE; any event that ends or refreshes the idle window zeroes it.
  temporizador_sessao #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_tmr (
    .clk(clk),
    .reset(reset),
    .clear(state != ACTIVE || logout || activity || expira),
    .enable(state == ACTIVE),
    .expira(expira)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= IDLE;
      codigo        <= 2'b00;
      {A, B, C}     <= 3'b000;
      perfil_atual  <= 2'b00;
      sessao_ativa  <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE:
          if (perfil_valid) begin
            codigo <= perfil_in;
            state  <= LOAD;
          end
        LOAD: begin
          {A, B, C}    <= decode_perfil(codigo);
          perfil_atual <= codigo;
          sessao_ativa <= 1'b1;
          state        <= ACTIVE;
        end
        ACTIVE:
          if (logout || (!activity && expira)) begin
            {A, B, C}     <= 3'b000;
            perfil_atual  <= 2'b00;
            sessao_ativa  <= 1'b0;
            timeout_pulse <= !logout;
            state         <= logout ? IDLE : EXPIRED;
          end
        EXPIRED: state <= IDLE;
      endcase
    end
endmodule
